// File: rtl/ula_issuer_pkg.sv
// ula_issuer_pkg: shared widths, FSM states and the packed ULA command
package ula_issuer_pkg;
    localparam int ULA_W = 4;
    localparam int ULA_OP_W = 2;
    typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;
    typedef struct packed {
        logic [ULA_W-1:0]    a;
        logic [ULA_W-1:0]    b;
        logic                cin;
        logic [ULA_OP_W-1:0] op;
    } cmd_t;
endpackage

// File: rtl/ula_cmd_fifo.sv
// ula_cmd_fifo: circular command buffer with wrapping pointers and occupancy count
module ula_cmd_fifo
    import ula_issuer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     din,
    output cmd_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    cmd_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/ula_issuer.sv
// ula_issuer: queues ULA commands, drives them one at a time, captures results (optional ULA_ISSUER_STATS_EN adds op_count)
module ula_issuer
    import ula_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ULA_W-1:0]    cmd_a,
    input  logic [ULA_W-1:0]    cmd_b,
    input  logic                cmd_cin,
    input  logic [ULA_OP_W-1:0] cmd_op,
    output logic [ULA_W-1:0]    ula_a,
    output logic [ULA_W-1:0]    ula_b,
    output logic                ula_cin,
    output logic [ULA_OP_W-1:0] ula_op,
    input  logic [ULA_W-1:0]    ula_s,
    input  logic                ula_cout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ULA_W-1:0]    res_s,
    output logic                res_cout,
    output logic [ULA_OP_W-1:0] res_op,
    output logic                busy
`ifdef ULA_ISSUER_STATS_EN
    ,
    output logic [7:0]          op_count
`endif
);
    state_t state;
    logic [3:0] cnt;
    cmd_t head;
    logic full, empty, push, pop;
    logic [$clog2(DEPTH):0] count;
    assign cmd_ready = !full;
    assign push = cmd_valid && !full;
    assign pop = state == IDLE && !empty;
    assign busy = state != IDLE || count != '0;
    ula_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din('{a: cmd_a, b: cmd_b, cin: cmd_cin, op: cmd_op}),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    // issue -> settle -> present result, with one idle bubble between results
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ula_a <= '0;
            ula_b <= '0;
            ula_cin <= 1'b0;
            ula_op <= '0;
            res_valid <= 1'b0;
            res_s <= '0;
            res_cout <= 1'b0;
            res_op <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    ula_a <= head.a;
                    ula_b <= head.b;
                    ula_cin <= head.cin;
                    ula_op <= head.op;
                    cnt <= 4'(WAIT_CYC - 1);
                    state <= SETTLE;
                end
                SETTLE: if (cnt == '0) begin
                    res_s <= ula_s;
                    res_cout <= ula_cout;
                    res_op <= ula_op;
                    res_valid <= 1'b1;
                    state <= RESULT;
                end else cnt <= cnt - 1'b1;
                RESULT: if (res_ready) begin
                    res_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ULA_ISSUER_STATS_EN
    // saturating count of completed result handshakes
    always_ff @(posedge clk) begin
        if (rst) op_count <= '0;
        else if (res_valid && res_ready && op_count != 8'hff) op_count <= op_count + 1'b1;
    end
`endif
endmodule
